exec_muldiv_ctrl: RTL
=====================

// Module: exec_muldiv_ctrl
// PURPOSE
//  Sequencer for the iterative multiply/divide unit beside the EX-stage ALU.
//  - Accepts one M-type op from the ID/EX register.
//  - Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
//  - Stalls IF/ID/EX while it runs, then presents one registered result to EX/MEM.
//  - Single-cycle ALU ops bypass this block entirely.
// PARAMETERS
//  XLEN      32  operand/result width (tracks `REG_SIZE)
//  CNT_W      6  iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst_n       in   1     synchronous, active-low reset
//  start_i     in   1     ID/EX holds a valid op this cycle
//  aluop_i     in   5     op code; only MD_* codes act
//  src1_i      in   XLEN  rs1 operand (multiplicand / dividend)
//  src2_i      in   XLEN  rs2 operand (multiplier / divisor)
//  dst_i       in   5     destination register index
//  flush_i     in   1     branch/exception kill of the in-flight op
//  busy_o      out  1     state != IDLE
//  stall_o     out  1     freeze PC, IF/ID and ID/EX
//  done_o      out  1     result_o/dst_o valid, one-cycle pulse
//  result_o    out  XLEN  product low/high, quotient or remainder
//  dst_o       out  5     dst captured at accept
//  div_zero_o  out  1     qualified by done_o: divisor was 0
//  overflow_o  out  1     qualified by done_o: signed INT_MIN / -1
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, all outputs 0, counter 0. Mid-op reset aborts with no done.
//  Accept: IDLE & start_i & aluop_i in MD_* & !flush_i. Non-MD ops are never accepted.
//  States and transitions:
//  - IDLE -> CALC on accept.
//    - Latch op, dst and |src1|,|src2| for signed ops; record result sign.
//  - CALC: one iteration per cycle, counter 0..XLEN-1; -> FIX after iteration XLEN-1.
//    - MUL*: 2*XLEN accumulator.
//    - DIV*/REM*: XLEN remainder + quotient shift register.
//  - FIX (1 cycle): apply two's-complement sign correction, select the result word; -> DONE.
//    - MUL: low word. MULH/MULHU: high word.
//    - Quotient sign = s1^s2. Remainder sign = s1.
//  - DONE (1 cycle): done_o=1, stall_o=0 so the pipeline advances and captures the result; -> IDLE.
//  Latency: done_o exactly XLEN+2 cycles after the accept edge (34 at XLEN=32).
//  stall_o = (IDLE & accept-condition) | CALC | FIX. It is combinational in the accept cycle so
//   ID/EX holds the op; DONE releases it.
//  Outputs result_o, dst_o and the flags are registered and change only on entry to DONE.
//   They hold their value otherwise; result_o is not cleared.
//  Divide by zero: skip CALC, FIX -> DONE in 2 cycles, div_zero_o=1.
//   Quotient = all ones; remainder = src1.
//  Overflow (DIV/REM, src1=INT_MIN, src2=-1): quotient = INT_MIN, remainder = 0, overflow_o=1.
//   Normal XLEN+2 latency applies.
//  flush_i: kills the op from any non-IDLE state -> IDLE next edge.
//   No done, stall_o deasserted that cycle. flush_i & start_i in IDLE: no accept.
//   flush_i in DONE: done_o forced 0.
//  start_i while busy_o: ignored; the pipeline must hold ID/EX while stall_o is high.
//  Width rules:
//  - Unsigned ops zero-extend; MULH sign-corrects the full 2*XLEN product.
//  - Iteration counter compares against XLEN-1; no wrap.
// STRUCTURE
//  define.v (shared):
//  - MD_MUL 5'h10, MD_MULH 5'h11, MD_MULHU 5'h12, MD_DIV 5'h13, MD_DIVU 5'h14,
//    MD_REM 5'h15, MD_REMU 5'h16.
//  - State encodings ST_IDLE/ST_CALC/ST_FIX/ST_DONE.
//  - is_md(op) macro, shared with the decoder.
//  Sub-module md_iter_core: per-cycle datapath step, purely combinational next-state.
//  - Mode mul/div.
//  - Add or subtract of the accumulator and remainder.
//  This module holds the FSM, counter, operand latches, sign fix-up and flush/stall logic.
// TESTING
//  - MUL 7 x 6 -> done_o at cycle +34, result_o=42, dst_o=dst_i, stall_o high cycles 0..33.
//  - MULH 0x80000000 x 2 -> 0xFFFFFFFF; MULHU same -> 0x00000001; MUL -3 x 5 -> 0xFFFFFFF1.
//  - DIV -7 / 2 -> quotient 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
//  - DIVU 5 / 0 -> done at +2, result_o=0xFFFFFFFF, div_zero_o=1.
//    REM 5 / 0 -> 5.
//    DIV 0x80000000 / -1 -> 0x80000000, overflow_o=1.
//  - flush_i at CALC cycle 10 -> IDLE next cycle, no done_o.
//    Immediate new MUL 3x3 -> 9 at +34. flush_i with start_i -> no accept.
//  - rst_n=0 in CALC cycle 20 -> all outputs 0 next edge.
//    start_i with aluop ADD -> never busy; start_i while busy -> ignored.

Source files
------------

// File: rtl/exec_muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//  - MD_* op codes (same encoding the decoder uses)
//  - FSM state encoding
//  - per-op context latched at accept
//  - op classification helpers (is_md is shared with the decoder)
package exec_muldiv_ctrl_pkg;

   localparam logic [4:0] MD_MUL   = 5'h10;
   localparam logic [4:0] MD_MULH  = 5'h11;
   localparam logic [4:0] MD_MULHU = 5'h12;
   localparam logic [4:0] MD_DIV   = 5'h13;
   localparam logic [4:0] MD_DIVU  = 5'h14;
   localparam logic [4:0] MD_REM   = 5'h15;
   localparam logic [4:0] MD_REMU  = 5'h16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // Everything about the op that must survive past the accept cycle.
   typedef struct packed {
      logic [4:0] op;
      logic       s1_neg;   // remainder / low-word sign
      logic       neg_q;    // product / quotient sign (s1 ^ s2)
      logic       dz;       // divisor was zero
      logic       ovf;      // signed INT_MIN / -1
      logic [4:0] dst;
   } md_ctx_t;

   function automatic logic is_md(input logic [4:0] op);
      return (op >= MD_MUL) && (op <= MD_REMU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op >= MD_DIV) && (op <= MD_REMU);
   endfunction

   // MUL is treated as signed: magnitude multiply plus sign fix gives the
   // same low word, so it shares the MULH path.
   function automatic logic is_signed(input logic [4:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/exec_muldiv_ctrl_if.sv
// Pipeline <-> mul/div sequencer bundle.
//  master : ID/EX side, drives the op and flush, observes stall/result
//  slave  : the sequencer
interface exec_muldiv_ctrl_if #(parameter int XLEN = 32) ();

   logic            start_i;
   logic [4:0]      aluop_i;
   logic [XLEN-1:0] src1_i;
   logic [XLEN-1:0] src2_i;
   logic [4:0]      dst_i;
   logic            flush_i;
   logic            busy_o;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0]      dst_o;
   logic            div_zero_o;
   logic            overflow_o;

   modport master (
      output start_i, aluop_i, src1_i, src2_i, dst_i, flush_i,
      input  busy_o, stall_o, done_o, result_o, dst_o, div_zero_o, overflow_o
   );

   modport slave (
      input  start_i, aluop_i, src1_i, src2_i, dst_i, flush_i,
      output busy_o, stall_o, done_o, result_o, dst_o, div_zero_o, overflow_o
   );

endinterface

// File: rtl/md_iter_core.sv
// One radix-2 iteration of the mul/div datapath, purely combinational.
//  mode_div : 0 = shift-add multiply, 1 = restoring divide
//  acc_i    : mul {partial hi, multiplier lo}; div {remainder, quotient/dividend}
//  opnd_i   : multiplicand (mul) or divisor (div), magnitudes only
//  acc_o    : accumulator after this iteration
module md_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              mode_div,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   sum;      // hi + multiplicand, carry kept for the shift
   logic [XLEN:0]   shl;      // remainder shifted left with next dividend bit
   logic [XLEN-1:0] rem_sub;
   logic            ge;

   always_comb begin
      sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      shl     = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      ge      = shl >= {1'b0, opnd_i};
      // When ge holds the true difference is < divisor, so XLEN bits suffice.
      rem_sub = shl[XLEN-1:0] - opnd_i;
      if (!mode_div)
         acc_o = {sum, acc_i[XLEN-1:1]};
      else if (ge)
         acc_o = {rem_sub, acc_i[XLEN-2:0], 1'b1};
      else
         acc_o = {shl[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/exec_muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit beside the EX-stage ALU.
// Accepts one MD_* op, iterates XLEN cycles on magnitudes, sign-fixes in FIX,
// then presents a registered result for one DONE cycle.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : slave side of exec_muldiv_ctrl_if (op in, stall/result out)
module exec_muldiv_ctrl
   import exec_muldiv_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   exec_muldiv_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_nxt, prod;
   logic [XLEN-1:0]   opnd_q;
   md_ctx_t           ctx_q;

   logic            accept, s1_neg, s2_neg, op_div, dz, ovf;
   logic [XLEN-1:0] abs1, abs2, quo, rem_raw, rem, res_fix;

   // Operand preparation for the accept cycle.
   always_comb begin
      s1_neg = is_signed(bus.aluop_i) & bus.src1_i[XLEN-1];
      s2_neg = is_signed(bus.aluop_i) & bus.src2_i[XLEN-1];
      abs1   = s1_neg ? -bus.src1_i : bus.src1_i;
      abs2   = s2_neg ? -bus.src2_i : bus.src2_i;
      op_div = is_div(bus.aluop_i);
      dz     = op_div && (bus.src2_i == '0);
      // INT_MIN / -1 needs no special datapath: |INT_MIN| / 1 with positive
      // sign already yields INT_MIN and remainder 0. Only the flag is extra.
      ovf    = ((bus.aluop_i == MD_DIV) || (bus.aluop_i == MD_REM)) &&
               (bus.src1_i == INT_MIN) && (bus.src2_i == '1);
      accept = (state_q == ST_IDLE) && bus.start_i && is_md(bus.aluop_i) && !bus.flush_i;
   end

   md_iter_core #(.XLEN(XLEN)) u_core (
      .mode_div (is_div(ctx_q.op)),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_nxt)
   );

   // Sign fix-up and word select, registered on FIX -> DONE.
   always_comb begin
      prod    = ctx_q.neg_q ? -acc_q : acc_q;
      quo     = ctx_q.dz ? '1 : (ctx_q.neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
      // With a zero divisor no iterations ran, so the dividend magnitude is
      // still in the low half; restoring its sign gives back src1.
      rem_raw = ctx_q.dz ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
      rem     = ctx_q.s1_neg ? -rem_raw : rem_raw;
      case (ctx_q.op)
         MD_MUL:           res_fix = prod[XLEN-1:0];
         MD_MULH, MD_MULHU: res_fix = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:  res_fix = quo;
         default:          res_fix = rem;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus.busy_o  = (state_q != ST_IDLE);
      bus.stall_o = 1'b0;
      bus.done_o  = 1'b0;
      case (state_q)
         ST_IDLE: if (accept) begin
            bus.stall_o = 1'b1;
            state_d     = dz ? ST_FIX : ST_CALC;
         end
         ST_CALC: if (bus.flush_i) state_d = ST_IDLE;
            else begin
               bus.stall_o = 1'b1;
               if (cnt_q == LAST) state_d = ST_FIX;
            end
         ST_FIX: if (bus.flush_i) state_d = ST_IDLE;
            else begin
               bus.stall_o = 1'b1;
               state_d     = ST_DONE;
            end
         ST_DONE: begin
            bus.done_o = !bus.flush_i;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         acc_q          <= '0;
         opnd_q         <= '0;
         ctx_q          <= '0;
         bus.result_o   <= '0;
         bus.dst_o      <= '0;
         bus.div_zero_o <= 1'b0;
         bus.overflow_o <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: if (accept) begin
               ctx_q  <= '{op: bus.aluop_i, s1_neg: s1_neg, neg_q: s1_neg ^ s2_neg,
                           dz: dz, ovf: ovf, dst: bus.dst_i};
               // mul: multiplier in low half; div: dividend in quotient half
               acc_q  <= {{XLEN{1'b0}}, op_div ? abs1 : abs2};
               opnd_q <= op_div ? abs2 : abs1;
               cnt_q  <= '0;
            end
            ST_CALC: begin
               acc_q <= acc_nxt;
               cnt_q <= (bus.flush_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
            ST_FIX: if (!bus.flush_i) begin
               bus.result_o   <= res_fix;
               bus.dst_o      <= ctx_q.dst;
               bus.div_zero_o <= ctx_q.dz;
               bus.overflow_o <= ctx_q.ovf;
            end
            default: ;
         endcase
      end
   end

endmodule
